// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA line timing generator.
//   VGA_state_e    : phase of one axis (SYNC, BACKPORCH, ACTIVE, FRONTPORCH)
//   vga_line_cfg_t : four phase lengths plus sync polarity
//   vga_next_state : phase order with zero-length porch skipping
// VGA_CFG_W bounds the LINE_WIDTH a vga_line_timer instance may use.
package vga_pkg;

  localparam int unsigned VGA_CFG_W = 16;

  typedef enum logic [1:0] {
    SYNC       = 2'd0,
    BACKPORCH  = 2'd1,
    ACTIVE     = 2'd2,
    FRONTPORCH = 2'd3
  } VGA_state_e;

  typedef struct packed {
    logic [VGA_CFG_W-1:0] visible_area;
    logic [VGA_CFG_W-1:0] front_porch;
    logic [VGA_CFG_W-1:0] sync_pulse;
    logic [VGA_CFG_W-1:0] back_porch;
    logic                 polarity;
  } vga_line_cfg_t;

  // Phase order SYNC->BP->ACTIVE->FP->SYNC, porches skipped when zero length.
  function automatic VGA_state_e vga_next_state(input VGA_state_e state,
                                                input vga_line_cfg_t cfg);
    VGA_state_e nxt;
    nxt = SYNC;
    case (state)
      SYNC:      nxt = (cfg.back_porch != '0) ? BACKPORCH : ACTIVE;
      BACKPORCH: nxt = ACTIVE;
      ACTIVE:    nxt = (cfg.front_porch != '0) ? FRONTPORCH : SYNC;
      default:   nxt = SYNC;
    endcase
    return nxt;
  endfunction

  // Length in ce cycles of the given phase.
  function automatic logic [VGA_CFG_W-1:0] vga_state_len(input VGA_state_e state,
                                                         input vga_line_cfg_t cfg);
    logic [VGA_CFG_W-1:0] len;
    len = cfg.front_porch;
    case (state)
      SYNC:      len = cfg.sync_pulse;
      BACKPORCH: len = cfg.back_porch;
      ACTIVE:    len = cfg.visible_area;
      default:   len = cfg.front_porch;
    endcase
    return len;
  endfunction

  // Visible and sync phases may never be empty; porches may.
  function automatic logic vga_cfg_legal(input vga_line_cfg_t cfg);
    return (cfg.visible_area != '0) && (cfg.sync_pulse != '0);
  endfunction

  // Force empty visible/sync phases to one cycle so the walk always advances.
  function automatic vga_line_cfg_t vga_cfg_sanitize(input vga_line_cfg_t cfg);
    vga_line_cfg_t c;
    c = cfg;
    if (c.visible_area == '0) c.visible_area = VGA_CFG_W'(1);
    if (c.sync_pulse == '0)   c.sync_pulse   = VGA_CFG_W'(1);
    return c;
  endfunction

endpackage

// File: rtl/vga_line_shadow.sv
// Pending/active timing register pair for vga_line_timer (shadow build only).
//   cfg_load/load_cfg : capture a new pending set (legality checked here)
//   wrap              : period boundary; pending set becomes the active set
//   primed            : low until the first boundary after reset; with no
//                       pending set the live inputs are adopted at that point
//   act_cfg           : timing set governing the current period
//   nxt_cfg_c         : set that will be active after a wrap in this cycle
//   cfg_err           : sticky illegal-load flag, cleared by a legal load
module vga_line_shadow
  import vga_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          cfg_load,
  input  vga_line_cfg_t load_cfg,
  input  logic          wrap,
  input  logic          primed,
  output vga_line_cfg_t act_cfg,
  output vga_line_cfg_t nxt_cfg_c,
  output logic          cfg_err
);

  vga_line_cfg_t pend_q, pend_d;
  vga_line_cfg_t act_q, act_d;
  logic          pend_vld_q, pend_vld_d;
  logic          err_q, err_d;

  // Set adopted at the coming boundary.
  always_comb begin
    nxt_cfg_c = act_q;
    if (pend_vld_q) begin
      nxt_cfg_c = pend_q;
    end else if (!primed) begin
      nxt_cfg_c = vga_cfg_sanitize(load_cfg);
    end
  end

  // A load in the wrap cycle lands in pending after the old pending is applied.
  always_comb begin
    pend_d     = pend_q;
    act_d      = act_q;
    pend_vld_d = pend_vld_q;
    err_d      = err_q;
    if (wrap) begin
      act_d      = nxt_cfg_c;
      pend_vld_d = 1'b0;
    end
    if (cfg_load) begin
      pend_d     = load_cfg;
      pend_vld_d = vga_cfg_legal(load_cfg);
      err_d      = ~vga_cfg_legal(load_cfg);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q     <= '0;
      act_q      <= '0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      act_q      <= act_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
    end
  end

  assign act_cfg = act_q;
  assign cfg_err = err_q;

endmodule

// File: rtl/vga_line_timer.sv
// One-axis VGA timing generator: walks SYNC -> BACKPORCH -> ACTIVE ->
// FRONTPORCH with a per-phase down-counter, skipping empty porches.
//   clk, rstn, ce        : pixel clock, async active-low reset, count enable
//   visible_area, front_porch, sync_pulse, back_porch, polarity : timing
//   cfg_load             : capture timing (shadow build only)
//   state, sync, active, pos : registered phase, sync level, active flag,
//                          active-pixel index
//   sol, eol             : ce-qualified start/end-of-period strobes
//                          (combinational, for zero-latency cascading)
//   cfg_err              : illegal configuration flag
// Build option VGA_LINE_TIMER_SHADOW_EN: timing is captured by cfg_load and
// applied at the next period wrap; otherwise each field is sampled live when
// its phase is entered. LINE_WIDTH must not exceed VGA_CFG_W.
module vga_line_timer
  import vga_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ce,
  input  logic [LINE_WIDTH-1:0] visible_area,
  input  logic [LINE_WIDTH-1:0] front_porch,
  input  logic [LINE_WIDTH-1:0] sync_pulse,
  input  logic [LINE_WIDTH-1:0] back_porch,
  input  logic                  polarity,
  input  logic                  cfg_load,
  output VGA_state_e            state,
  output logic                  sync,
  output logic                  active,
  output logic [LINE_WIDTH-1:0] pos,
  output logic                  sol,
  output logic                  eol,
  output logic                  cfg_err
);

  vga_line_cfg_t         live_cfg;
  vga_line_cfg_t         cur_cfg;
  vga_line_cfg_t         wrap_cfg;
  vga_line_cfg_t         entry_cfg;
  VGA_state_e            state_q, state_d;
  VGA_state_e            nxt_state;
  logic [LINE_WIDTH-1:0] remain_q, remain_d;
  logic [LINE_WIDTH-1:0] pos_q, pos_d;
  logic                  sync_q, sync_d;
  logic                  primed_q, primed_d;
  logic                  last_c;
  logic                  wrap_c;

  // Port fields widened into the shared config record.
  always_comb begin
    live_cfg              = '0;
    live_cfg.visible_area = VGA_CFG_W'(visible_area);
    live_cfg.front_porch  = VGA_CFG_W'(front_porch);
    live_cfg.sync_pulse   = VGA_CFG_W'(sync_pulse);
    live_cfg.back_porch   = VGA_CFG_W'(back_porch);
    live_cfg.polarity     = polarity;
  end

`ifdef VGA_LINE_TIMER_SHADOW_EN
  logic shadow_err;

  vga_line_shadow u_shadow (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_load  (cfg_load),
    .load_cfg  (live_cfg),
    .wrap      (wrap_c),
    .primed    (primed_q),
    .act_cfg   (cur_cfg),
    .nxt_cfg_c (wrap_cfg),
    .cfg_err   (shadow_err)
  );

  assign cfg_err = shadow_err;
`else
  logic cfg_err_q, cfg_err_d;
  logic unused_cfg_load;

  // Live timing; empty visible/sync phases run as one cycle.
  assign cur_cfg         = vga_cfg_sanitize(live_cfg);
  assign wrap_cfg        = cur_cfg;
  assign cfg_err_d       = ~vga_cfg_legal(live_cfg);
  assign unused_cfg_load = cfg_load;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;
`endif

  // Phase decision uses the current set; the wrap into SYNC uses the new one.
  assign nxt_state = vga_next_state(state_q, cur_cfg);
  assign last_c    = (remain_q == '0);
  assign wrap_c    = ce & last_c & (nxt_state == SYNC);
  assign entry_cfg = (nxt_state == SYNC) ? wrap_cfg : cur_cfg;

  // Next-state: count down within a phase, reload on phase change.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    pos_d    = pos_q;
    sync_d   = sync_q;
    primed_d = primed_q;
    if (ce) begin
      if (!last_c) begin
        remain_d = remain_q - LINE_WIDTH'(1);
        if (state_q == ACTIVE) begin
          pos_d = pos_q + LINE_WIDTH'(1);
        end
      end else begin
        state_d  = nxt_state;
        remain_d = LINE_WIDTH'(vga_state_len(nxt_state, entry_cfg) - VGA_CFG_W'(1));
        pos_d    = '0;
        sync_d   = (nxt_state == SYNC) ? entry_cfg.polarity : ~entry_cfg.polarity;
        primed_d = 1'b1;
      end
    end
  end

  // Reset parks in FRONTPORCH with nothing left, so the first ce enters SYNC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= FRONTPORCH;
      remain_q <= '0;
      pos_q    <= '0;
      sync_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      pos_q    <= pos_d;
      sync_q   <= sync_d;
      primed_q <= primed_d;
    end
  end

  assign state  = state_q;
  assign sync   = sync_q;
  assign active = (state_q == ACTIVE);
  assign pos    = pos_q;
  // sol is held low while reset is asserted even if ce is high.
  assign sol    = wrap_c & rstn;
  assign eol    = wrap_c & primed_q;

endmodule

// File: tb/tb_vga_line_timer.sv
// Self-checking bench for vga_line_timer: directed literal sequences,
// randomized timing/ce/reset stimulus against a phase-walk model, and a
// horizontal->vertical cascade pair. Build option VGA_LINE_TIMER_SHADOW_EN
// enables the shadow-register scenarios.
module tb_vga_line_timer;
  import vga_pkg::*;

  localparam int unsigned LW = 12;
  localparam int S_SYNC = 0;
  localparam int S_BP   = 1;
  localparam int S_ACT  = 2;
  localparam int S_FP   = 3;

  logic          clk = 1'b0;
  logic          rstn, rstn_c, ce, pol, cfg_load;
  logic [LW-1:0] vis, fp, sp, bp;
  VGA_state_e    st;
  logic          sync, active, sol, eol, cfg_err;
  logic [LW-1:0] pos;

  VGA_state_e    h_st, v_st;
  logic          h_sync, h_active, h_sol, h_eol, h_err;
  logic          v_sync, v_active, v_sol, v_eol, v_err;
  logic [LW-1:0] h_pos, v_pos;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vga_line_timer #(.LINE_WIDTH(LW)) dut (
    .clk(clk), .rstn(rstn), .ce(ce),
    .visible_area(vis), .front_porch(fp), .sync_pulse(sp), .back_porch(bp),
    .polarity(pol), .cfg_load(cfg_load),
    .state(st), .sync(sync), .active(active), .pos(pos),
    .sol(sol), .eol(eol), .cfg_err(cfg_err)
  );

  // Horizontal: 8-cycle line. Vertical: sync 1, visible 2, no porches.
  vga_line_timer #(.LINE_WIDTH(LW)) u_h (
    .clk(clk), .rstn(rstn_c), .ce(1'b1),
    .visible_area(12'd4), .front_porch(12'd1), .sync_pulse(12'd2), .back_porch(12'd1),
    .polarity(1'b0), .cfg_load(1'b0),
    .state(h_st), .sync(h_sync), .active(h_active), .pos(h_pos),
    .sol(h_sol), .eol(h_eol), .cfg_err(h_err)
  );

  vga_line_timer #(.LINE_WIDTH(LW)) u_v (
    .clk(clk), .rstn(rstn_c), .ce(h_eol),
    .visible_area(12'd2), .front_porch(12'd0), .sync_pulse(12'd1), .back_porch(12'd0),
    .polarity(1'b1), .cfg_load(1'b0),
    .state(v_st), .sync(v_sync), .active(v_active), .pos(v_pos),
    .sol(v_sol), .eol(v_eol), .cfg_err(v_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int vis;
    int fp;
    int sp;
    int bp;
    bit pol;
  } mcfg_t;

  int    m_st, m_el, m_len, m_nx;
  bit    m_pr, m_sync, m_last, m_wr, m_err, m_pvld;
  mcfg_t m_act, m_pend, m_live, m_dec, m_ent;

  function automatic mcfg_t ports_cfg();
    mcfg_t c;
    c.vis = int'(vis); c.fp = int'(fp); c.sp = int'(sp); c.bp = int'(bp); c.pol = pol;
    return c;
  endfunction

  function automatic mcfg_t clamp(input mcfg_t c);
    mcfg_t r;
    r = c;
    if (r.vis < 1) r.vis = 1;
    if (r.sp < 1) r.sp = 1;
    return r;
  endfunction

  function automatic bit legal(input mcfg_t c);
    return (c.vis != 0) && (c.sp != 0);
  endfunction

  function automatic int m_next(input int s, input mcfg_t c);
    case (s)
      S_SYNC:  return (c.bp != 0) ? S_BP : S_ACT;
      S_BP:    return S_ACT;
      S_ACT:   return (c.fp != 0) ? S_FP : S_SYNC;
      default: return S_SYNC;
    endcase
  endfunction

  function automatic int m_length(input int s, input mcfg_t c);
    case (s)
      S_SYNC:  return c.sp;
      S_BP:    return c.bp;
      S_ACT:   return c.vis;
      default: return c.fp;
    endcase
  endfunction

  // Compare on the falling edge, then advance the model across the next rise.
  always @(negedge clk) begin
    if (!rstn) begin
      m_st = S_FP; m_el = 0; m_len = 1; m_pr = 0; m_sync = 0;
      m_err = 0; m_pvld = 0; m_act = '{0, 0, 0, 0, 1'b0};
      chk("rst_state", int'(st), S_FP);
      chk("rst_sync", int'(sync), 0);
      chk("rst_active", int'(active), 0);
      chk("rst_pos", int'(pos), 0);
      chk("rst_sol", int'(sol), 0);
      chk("rst_eol", int'(eol), 0);
      chk("rst_cfg_err", int'(cfg_err), 0);
    end else begin
      m_live = ports_cfg();
`ifdef VGA_LINE_TIMER_SHADOW_EN
      m_dec = m_act;
`else
      m_dec = clamp(m_live);
`endif
      m_last = (m_el == m_len - 1);
      m_nx   = m_next(m_st, m_dec);
      m_wr   = ce && m_last && (m_nx == S_SYNC);
      chk("state", int'(st), m_st);
      chk("active", int'(active), int'(m_st == S_ACT));
      chk("pos", int'(pos), (m_st == S_ACT) ? m_el : 0);
      chk("sync", int'(sync), int'(m_sync));
      chk("sol", int'(sol), int'(m_wr));
      chk("eol", int'(eol), int'(m_wr && m_pr));
      chk("cfg_err", int'(cfg_err), int'(m_err));
`ifndef VGA_LINE_TIMER_SHADOW_EN
      m_err = !legal(m_live);
`endif
      if (ce) begin
        if (!m_last) begin
          m_el++;
        end else begin
          m_ent = m_dec;
`ifdef VGA_LINE_TIMER_SHADOW_EN
          if (m_nx == S_SYNC) begin
            if (m_pvld) m_act = m_pend;
            else if (!m_pr) m_act = clamp(m_live);
            m_pvld = 0;
            m_ent = m_act;
          end
`endif
          m_st = m_nx; m_el = 0; m_len = m_length(m_nx, m_ent);
          m_sync = (m_nx == S_SYNC) ? m_ent.pol : !m_ent.pol;
          m_pr = 1;
        end
      end
`ifdef VGA_LINE_TIMER_SHADOW_EN
      if (cfg_load) begin
        if (legal(m_live)) begin m_pend = m_live; m_pvld = 1; m_err = 0; end
        else begin m_pvld = 0; m_err = 1; end
      end
`endif
    end
  end

  // ---------------- cascade check ----------------
  bit casc_on = 0;
  int k_c = -1;
  int n_eol = 0;
  int exp_vs, exp_vp;

  always @(negedge clk) begin
    if (casc_on) begin
      k_c++;
      chk("casc_h_eol", int'(h_eol), int'(k_c >= 8 && k_c % 8 == 0));
      exp_vs = (n_eol == 0) ? S_FP : (((n_eol - 1) % 3 == 0) ? S_SYNC : S_ACT);
      exp_vp = (exp_vs == S_ACT) ? ((n_eol - 1) % 3) - 1 : 0;
      chk("casc_v_state", int'(v_st), exp_vs);
      chk("casc_v_pos", int'(v_pos), exp_vp);
      if (h_eol) n_eol++;
    end
  end

  // ---------------- directed literal expectations ----------------
  int t1_st[9]   = '{3, 0, 0, 1, 2, 2, 2, 2, 3};
  int t1_pos[9]  = '{0, 0, 0, 0, 0, 1, 2, 3, 0};
  int t1_sync[9] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
  int t1_sol[9]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
  int t1_eol[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
  int t2_st[8]   = '{3, 0, 0, 2, 2, 2, 2, 0};
  int t2_eol[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};

  task automatic set_cfg(input int v, input int f, input int s, input int b, input bit p);
    vis = LW'(v); fp = LW'(f); sp = LW'(s); bp = LW'(b); pol = p;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rstn = 1'b0; ce = 1'b0; cfg_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Falling edges until sol is seen (inclusive); 0 if the bound expires.
  task automatic wait_sol(output int cnt);
    cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (sol) begin cnt = i; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit found;
    rstn = 1'b1; rstn_c = 1'b1; ce = 1'b0; cfg_load = 1'b0;
    set_cfg(4, 1, 2, 1, 1'b0);
    #1 rstn = 1'b0; rstn_c = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn_c = 1'b1; casc_on = 1;

    // Basic 8-cycle line.
    set_cfg(4, 1, 2, 1, 1'b0);
    apply_reset();
    rstn = 1'b1; ce = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t1_state", int'(st), t1_st[i]);
      chk("t1_pos", int'(pos), t1_pos[i]);
      chk("t1_sync", int'(sync), t1_sync[i]);
      chk("t1_sol", int'(sol), t1_sol[i]);
      chk("t1_eol", int'(eol), t1_eol[i]);
    end

    // No porches: ACTIVE wraps straight to SYNC.
    set_cfg(4, 0, 2, 0, 1'b0);
    apply_reset();
    rstn = 1'b1; ce = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_state", int'(st), t2_st[i]);
      chk("t2_eol", int'(eol), t2_eol[i]);
    end

    // ce toggling: strobes never fire on ce=0.
    set_cfg(4, 1, 2, 1, 1'b0);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      ce = (i % 2 == 0);
      @(negedge clk);
      if (!ce) begin
        chk("t3_sol_quiet", int'(sol), 0);
        chk("t3_eol_quiet", int'(eol), 0);
      end
    end

    // Asynchronous reset in the middle of ACTIVE.
    @(posedge clk); #1 ce = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (active && pos == LW'(2)) begin found = 1; break; end
    end
    chk("t4_found_active", int'(found), 1);
    @(posedge clk); #2 rstn = 1'b0;
    #1;
    chk("t4_async_state", int'(st), S_FP);
    chk("t4_async_active", int'(active), 0);
    chk("t4_async_pos", int'(pos), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("t4_first_sol", int'(sol), 1);
    @(negedge clk);
    chk("t4_enter_sync", int'(st), S_SYNC);

`ifdef VGA_LINE_TIMER_SHADOW_EN
    // Deferred reload and illegal-load rejection.
    set_cfg(4, 1, 2, 1, 1'b0);
    apply_reset();
    rstn = 1'b1; ce = 1'b1;
    wait_sol(c); chk("sh_first_sol", c, 1);
    wait_sol(c); chk("sh_period_a", c, 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (active) break;
    end
    @(posedge clk); #1 vis = LW'(6); cfg_load = 1'b1;
    @(posedge clk); #1 cfg_load = 1'b0;
    wait_sol(c); chk("sh_current_kept", c, 3);
    wait_sol(c); chk("sh_period_new", c, 10);
    @(posedge clk); #1 sp = LW'(0); cfg_load = 1'b1;
    @(posedge clk); #1 cfg_load = 1'b0;
    @(negedge clk); chk("sh_err_set", int'(cfg_err), 1);
    wait_sol(c);
    wait_sol(c); chk("sh_period_unchanged", c, 10);
    @(posedge clk); #1 sp = LW'(2); cfg_load = 1'b1;
    @(posedge clk); #1 cfg_load = 1'b0;
    @(negedge clk); chk("sh_err_clear", int'(cfg_err), 0);
`endif

    // Randomized timing, ce patterns, reloads and resets.
    for (int blk = 0; blk < 60; blk++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 50; i++) begin
        @(posedge clk); #1;
        case (mode)
          0:       ce = 1'b1;
          1:       ce = (i % 2 == 0);
          default: ce = ($urandom_range(0, 3) != 0);
        endcase
        cfg_load = 1'b0;
        if ($urandom_range(0, 19) == 0) begin
          set_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
          cfg_load = 1'($urandom_range(0, 1));
        end
        rstn = ($urandom_range(0, 399) != 0);
      end
    end

    @(posedge clk); #1 rstn = 1'b1; ce = 1'b1; cfg_load = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_line_timer.md
# vga_line_timer

Parametrised, FSM-based timing generator for one VGA axis (horizontal or vertical); the successor to the comparator-based line counter. It walks SYNC → BACKPORCH → ACTIVE → FRONTPORCH with per-state down-counters, skips zero-length porches, and exports an active-pixel position plus period-boundary strobes. Two instances cascade into a full frame generator: the horizontal instance's `eol` drives the vertical instance's `ce`. Timing fields can be reloaded at run time and take effect only at a period boundary.

## Interface
- `LINE_WIDTH`, 12: width of every timing field and of `pos`.
- `clk` in 1: pixel clock.
- `rstn` in 1: asynchronous, active-low reset.
- `ce` in 1: count enable. Tie to 1 for horizontal; tie to the horizontal `eol` for vertical.
- `visible_area`, `front_porch`, `sync_pulse`, `back_porch` in LINE_WIDTH each: state lengths in `ce` cycles.
- `polarity` in 1: 1 = sync active-high, 0 = active-low.
- `cfg_load` in 1: single-cycle strobe that captures the timing fields.
- `state` out VGA_state_e: current phase.
- `sync` out 1: registered sync output.
- `active` out 1: high while `state == ACTIVE`.
- `pos` out LINE_WIDTH: index in the active area, 0..visible_area-1; 0 outside ACTIVE.
- `sol` out 1: `ce`-qualified pulse on the first cycle of SYNC.
- `eol` out 1: `ce`-qualified pulse on the last cycle of the period.
- `cfg_err` out 1: sticky flag for an illegal configuration.

## Operation
- Internal registers:
  - `state_q`.
  - `remain_q`: cycles left in the state, minus 1.
  - `pos_q`, `sync_q`.
  - `primed_q`: 0 after reset.
- On `ce=1`:
  - If `remain_q != 0`: decrement `remain_q`. In ACTIVE, also increment `pos_q`.
  - If `remain_q == 0`: move to the next state in the order SYNC→BP→ACTIVE→FP→SYNC. Skip BP or FP when its length is 0. Load `remain_q` with length-1. Set `pos_q` to 0. Set `sync_q = polarity` when entering SYNC, else `~polarity`. Set `primed_q` to 1.
- With `ce=0`, all registers hold.
- Wrap point is the FP→SYNC transition, or ACTIVE→SYNC when `front_porch=0`. The effective timing set is latched there.
- `eol = ce & primed_q & (remain_q==0) & (the next transition is the wrap)`. This term is combinational from registers and `ce`.
- `sol = ce & (the transition enters SYNC)`. It is also asserted on the first `ce` after reset.
- Legality: `visible_area` and `sync_pulse` must be ≥1; porches may be 0.
- Reset state: `state_q=FRONTPORCH`, `remain_q=0`, `primed_q=0`. The first `ce` therefore enters SYNC and latches the configuration.
- Reset values: `state=FRONTPORCH`, `sync=0`, `active=0`, `pos=0`, `sol=0`, `eol=0`, `cfg_err=0`.
- Widths: length-1 arithmetic is LINE_WIDTH bits. No period total is computed, so there is no overflow path.
- Asserting reset mid-period returns the block immediately to the reset state (asynchronous reset).

## Timing
- `state`, `sync`, `active` and `pos` are registered. They change one clock after the `ce` cycle that caused the transition.
- `sol` and `eol` are valid in the same cycle as the `ce` they qualify. This gives zero-latency cascading.
- Period = `sync + bp + visible + fp` `ce` cycles.
- `cfg_load` coinciding with a wrap: the new values apply from the next wrap, not the current one.
- A second `cfg_load` before a wrap overwrites the pending values.

## Configuration
- `VGA_LINE_TIMER_SHADOW_EN` defined:
  - `cfg_load` captures the fields into a pending register set.
  - The pending set is copied to the active set at the next wrap.
  - An illegal pending set (visible or sync = 0) is not applied. `cfg_err` sets, and clears on the next legal `cfg_load`.
- Not defined:
  - `cfg_load` is ignored.
  - Each field is sampled directly from the ports when its state is entered.
  - A zero visible or sync length is treated as 1.
  - `cfg_err` is high while the live inputs are illegal (non-sticky).

## Structure
- `vga_pkg` holds:
  - `VGA_state_e` (SYNC, BACKPORCH, ACTIVE, FRONTPORCH).
  - A `vga_line_cfg_t` struct (four lengths + polarity).
  - A function `vga_next_state(state, cfg)` implementing the skip rule.
- One sub-module: `vga_line_shadow`, the pending/active register pair with legality check. It is instantiated only under the macro.

## Test plan
- Config visible=4, fp=1, sync=2, bp=1, pol=0; `ce=1` from the first clock after reset release:
  - States are SYNC,SYNC,BP,A,A,A,A,FP, then repeat (period 8).
  - `sync=0` on the two SYNC cycles; `pos` is 0,1,2,3 during A.
  - `eol` pulses in the FP cycle; `sol` pulses on the `ce` cycle that enters SYNC (the FP cycle).
- Same config with fp=0 and bp=0: period 6; ACTIVE→SYNC directly; `eol` pulses on the last ACTIVE cycle.
- `ce` toggling 1,0,1,0: every output holds on `ce=0` cycles; no `eol` or `sol` pulse on `ce=0`.
- Shadow build: `cfg_load` with visible=6 issued mid-ACTIVE:
  - The current period keeps visible=4.
  - The next period has visible=6 (period 10).
  - `cfg_load` with sync=0 sets `cfg_err`, timing stays unchanged, and a later legal load clears `cfg_err`.
- `rstn` asserted mid-ACTIVE: outputs go to their reset values asynchronously; after release, the first `ce` yields SYNC.
- Cascade: horizontal (8-cycle) instance driving vertical (visible=2, fp=0, sync=1, bp=0): vertical state advances exactly once every 8 clocks, aligned with horizontal `eol`.
